// File: rtl/plru_pkg.sv
// Shared PLRU tree helpers: victim walk, touch update and invalid-way priority encoder.
// Functions work on 32-bit padded vectors so one body serves any NWAY up to 32.
package plru_pkg;

    localparam int unsigned MAX_WAY_W = 5;
    localparam int unsigned MAX_VEC_W = 32;

    typedef logic [MAX_WAY_W-1:0] pway_t;
    typedef logic [MAX_VEC_W-1:0] pvec_t;

    typedef struct packed {
        pway_t way;
        pvec_t vec;
    } walk_t;

    typedef enum logic {StIdle, StResp} fsm_e;

    // Node n lives at bit n-1; children of n are 2n and 2n+1, so the next node
    // is the current one shifted left with the direction bit appended.
    function automatic walk_t plru_walk(input pvec_t vec, input int unsigned way_w);
        walk_t res;
        pway_t node;
        logic  b;
        res.way = '0;
        res.vec = vec;
        node    = pway_t'(1);
        for (int unsigned lvl = 0; lvl < MAX_WAY_W; lvl++) begin
            if (lvl < way_w) begin
                b                     = vec[node - 1'b1];
                res.vec[node - 1'b1]  = ~b;
                res.way               = {res.way[MAX_WAY_W-2:0], b};
                node                  = {node[MAX_WAY_W-2:0], b};
            end
        end
        return res;
    endfunction

    function automatic pvec_t plru_touch(input pvec_t vec, input pway_t way,
                                         input int unsigned way_w);
        pvec_t res;
        pway_t node;
        pway_t path;
        logic  d;
        res  = vec;
        node = pway_t'(1);
        path = way << (MAX_WAY_W - way_w);
        for (int unsigned lvl = 0; lvl < MAX_WAY_W; lvl++) begin
            if (lvl < way_w) begin
                d                 = path[MAX_WAY_W-1];
                res[node - 1'b1]  = ~d;
                node              = {node[MAX_WAY_W-2:0], d};
                path              = path << 1;
            end
        end
        return res;
    endfunction

    function automatic pway_t plru_first_set(input pvec_t mask);
        pway_t idx;
        idx = '0;
        for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = pway_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_touch_update.sv
// Combinational touch: rewrites the tree so every node on the path points away from i_way.
module plru_touch_update
    import plru_pkg::*;
#(
    parameter int unsigned NWAY = 8
) (
    input  logic [NWAY-2:0]         i_vec,
    input  logic [$clog2(NWAY)-1:0] i_way,
    output logic [NWAY-2:0]         o_vec
);

    localparam int unsigned WAY_W = $clog2(NWAY);
    localparam int unsigned LRU_W = NWAY - 1;

    pvec_t w_full;
    logic  w_unused_hi;

    assign w_full      = plru_touch(pvec_t'(i_vec), pway_t'(i_way), WAY_W);
    assign o_vec       = w_full[LRU_W-1:0];
    assign w_unused_hi = ^w_full;

endmodule

// File: rtl/plru_set_tracker.sv
// Per-set binary-tree PLRU store: hit touches every cycle plus a registered
// victim request/response handshake for the refill path.
module plru_set_tracker
    import plru_pkg::*;
#(
    parameter int unsigned NSET  = 64,
    parameter int unsigned NWAY  = 8,
    parameter int unsigned WAY_W = $clog2(NWAY),
    parameter int unsigned SET_W = $clog2(NSET),
    parameter int unsigned LRU_W = NWAY - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             touch_vld_i,
    input  logic [SET_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             vreq_vld_i,
    output logic             vreq_rdy_o,
    input  logic [SET_W-1:0] vreq_set_i,
    input  logic [NWAY-1:0]  vreq_inv_i,
    output logic             vresp_vld_o,
    input  logic             vresp_rdy_i,
    output logic [SET_W-1:0] vresp_set_o,
    output logic [WAY_W-1:0] vresp_way_o
);

    logic [LRU_W-1:0] r_vec [NSET];

    fsm_e             r_state;
    logic             r_vresp_vld;
    logic [SET_W-1:0] r_vresp_set;
    logic [WAY_W-1:0] r_vresp_way;

    logic             w_accept;
    logic             w_same_set;
    logic [LRU_W-1:0] w_touch_cur;
    logic [LRU_W-1:0] w_touch_vec;
    logic [LRU_W-1:0] w_vbase;
    logic [LRU_W-1:0] w_victim_vec;
    walk_t            w_walk;
    pway_t            w_inv_way;
    logic [WAY_W-1:0] w_vway;
    logic             w_unused_walk;

    assign w_touch_cur = r_vec[touch_set_i];

    plru_touch_update #(
        .NWAY (NWAY)
    ) u_touch (
        .i_vec (w_touch_cur),
        .i_way (touch_way_i),
        .o_vec (w_touch_vec)
    );

    // A same-set hit lands first, so the victim walk sees the touched tree.
    assign w_same_set = touch_vld_i && (touch_set_i == vreq_set_i);
    assign w_vbase    = w_same_set ? w_touch_vec : r_vec[vreq_set_i];

    assign w_walk     = plru_walk(pvec_t'(w_vbase), WAY_W);
    assign w_inv_way  = plru_first_set(pvec_t'(vreq_inv_i));
    assign w_vway     = (|vreq_inv_i) ? w_inv_way[WAY_W-1:0] : w_walk.way[WAY_W-1:0];

    assign w_unused_walk = ^{w_walk, w_inv_way};

    plru_touch_update #(
        .NWAY (NWAY)
    ) u_victim (
        .i_vec (w_vbase),
        .i_way (w_vway),
        .o_vec (w_victim_vec)
    );

    assign vreq_rdy_o  = (r_state == StIdle) || vresp_rdy_i;
    assign w_accept    = vreq_vld_i && vreq_rdy_o;
    assign vresp_vld_o = r_vresp_vld;
    assign vresp_set_o = r_vresp_set;
    assign vresp_way_o = r_vresp_way;

    // The victim write is issued last so a same-set commit carries the merged result.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int unsigned s = 0; s < NSET; s++) begin
                r_vec[s] <= '0;
            end
        end else begin
            if (touch_vld_i) begin
                r_vec[touch_set_i] <= w_touch_vec;
            end
            if (w_accept) begin
                r_vec[vreq_set_i] <= w_victim_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_vresp_vld <= 1'b0;
            r_vresp_set <= '0;
            r_vresp_way <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (vreq_vld_i) begin
                        r_state     <= StResp;
                        r_vresp_vld <= 1'b1;
                        r_vresp_set <= vreq_set_i;
                        r_vresp_way <= w_vway;
                    end
                end
                StResp: begin
                    if (vresp_rdy_i) begin
                        if (vreq_vld_i) begin
                            r_vresp_set <= vreq_set_i;
                            r_vresp_way <= w_vway;
                        end else begin
                            r_state     <= StIdle;
                            r_vresp_vld <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_vresp_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plru_set_tracker.sv
// Directed + randomized bench for plru_set_tracker against a node-array tree model.
module tb_plru_set_tracker;

    logic       clk;
    logic       rst;
    logic       flush_i;
    logic       touch_vld_i;
    logic [5:0] touch_set_i;
    logic [2:0] touch_way_i;
    logic       vreq_vld_i;
    logic       vreq_rdy_o;
    logic [5:0] vreq_set_i;
    logic [7:0] vreq_inv_i;
    logic       vresp_vld_o;
    logic       vresp_rdy_i;
    logic [5:0] vresp_set_o;
    logic [2:0] vresp_way_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: per set, direction bit per 1-based node (1..7); plus expected response regs.
    int m_tree [64][8];
    bit m_vld;
    int m_set;
    int m_way;

    plru_set_tracker #(
        .NSET (64),
        .NWAY (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .touch_vld_i (touch_vld_i),
        .touch_set_i (touch_set_i),
        .touch_way_i (touch_way_i),
        .vreq_vld_i  (vreq_vld_i),
        .vreq_rdy_o  (vreq_rdy_o),
        .vreq_set_i  (vreq_set_i),
        .vreq_inv_i  (vreq_inv_i),
        .vresp_vld_o (vresp_vld_o),
        .vresp_rdy_i (vresp_rdy_i),
        .vresp_set_o (vresp_set_o),
        .vresp_way_o (vresp_way_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 64; s++) begin
            for (int n = 0; n < 8; n++) begin
                m_tree[s][n] = 0;
            end
        end
    endtask

    function automatic int m_walk(input int s);
        int n = 1;
        int w = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            w = 2 * w + m_tree[s][n];
            n = 2 * n + m_tree[s][n];
        end
        return w;
    endfunction

    task automatic m_touch(input int s, input int w);
        int n = 1;
        int d;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            d = (w >> lvl) & 1;
            m_tree[s][n] = 1 - d;
            n = 2 * n + d;
        end
    endtask

    function automatic int m_lowest(input logic [7:0] inv);
        for (int i = 0; i < 8; i++) begin
            if (inv[i]) return i;
        end
        return -1;
    endfunction

    // One clock: drive at edge+1, check ready before the edge, check response after it.
    task automatic cycle(input bit t_vld, input int t_set, input int t_way,
                         input bit r_vld, input int r_set, input logic [7:0] inv,
                         input bit rsp_rdy, input bit fl);
        bit acc;
        int w;
        touch_vld_i = t_vld;
        touch_set_i = 6'(t_set);
        touch_way_i = 3'(t_way);
        vreq_vld_i  = r_vld;
        vreq_set_i  = 6'(r_set);
        vreq_inv_i  = inv;
        vresp_rdy_i = rsp_rdy;
        flush_i     = fl;
        #1;
        chk("vreq_rdy", 32'(vreq_rdy_o), 32'(!m_vld || rsp_rdy));
        acc = r_vld && (!m_vld || rsp_rdy);
        if (t_vld) m_touch(t_set, t_way);
        if (acc) begin
            w = (inv != 0) ? m_lowest(inv) : m_walk(r_set);
            m_touch(r_set, w);
            m_vld = 1'b1;
            m_set = r_set;
            m_way = w;
        end else if (m_vld && rsp_rdy) begin
            m_vld = 1'b0;
        end
        if (fl) m_clear();
        @(posedge clk);
        #1;
        chk("vresp_vld", 32'(vresp_vld_o), 32'(m_vld));
        if (m_vld) begin
            chk("vresp_set", 32'(vresp_set_o), 32'(m_set));
            chk("vresp_way", 32'(vresp_way_o), 32'(m_way));
        end
    endtask

    task automatic idle(input bit rsp_rdy);
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00, rsp_rdy, 1'b0);
    endtask

    task automatic req(input int s, input logic [7:0] inv);
        cycle(1'b0, 0, 0, 1'b1, s, inv, 1'b1, 1'b0);
    endtask

    initial begin
        int held_set;
        int held_way;
        int sets [6];
        rst         = 1'b1;
        flush_i     = 1'b0;
        touch_vld_i = 1'b0;
        touch_set_i = '0;
        touch_way_i = '0;
        vreq_vld_i  = 1'b0;
        vreq_set_i  = '0;
        vreq_inv_i  = '0;
        vresp_rdy_i = 1'b1;
        m_clear();
        m_vld = 1'b0;
        m_set = 0;
        m_way = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vresp_vld", 32'(vresp_vld_o), 32'd0);
        chk("rst_vresp_set", 32'(vresp_set_o), 32'd0);
        chk("rst_vresp_way", 32'(vresp_way_o), 32'd0);
        chk("rst_vreq_rdy", 32'(vreq_rdy_o), 32'd1);

        // Fresh tree walks to way 0, then the flipped root sends the next walk to way 4.
        req(3, 8'h00);
        chk("s3_first_way", 32'(vresp_way_o), 32'd0);
        req(3, 8'h00);
        chk("s3_second_way", 32'(vresp_way_o), 32'd4);
        idle(1'b1);

        cycle(1'b1, 5, 5, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        req(5, 8'h00);
        chk("s5_after_touch5", 32'(vresp_way_o), 32'd0);

        req(2, 8'b0010_0100);
        chk("s2_inv_way", 32'(vresp_way_o), 32'd2);
        req(2, 8'h00);
        chk("s2_walk_after_inv", 32'(vresp_way_o), 32'd4);

        cycle(1'b1, 7, 0, 1'b1, 7, 8'h00, 1'b1, 1'b0);
        chk("s7_touch_first", 32'(vresp_way_o), 32'd4);
        req(7, 8'h00);
        chk("s7_combined", 32'(vresp_way_o), 32'd2);
        idle(1'b1);

        // Backpressure: response must hold while a second request waits.
        cycle(1'b0, 0, 0, 1'b1, 10, 8'h00, 1'b0, 1'b0);
        held_set = m_set;
        held_way = m_way;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, 0, 1'b1, 11, 8'h00, 1'b0, 1'b0);
            chk("bp_hold_vld", 32'(vresp_vld_o), 32'd1);
            chk("bp_hold_set", 32'(vresp_set_o), 32'(held_set));
            chk("bp_hold_way", 32'(vresp_way_o), 32'(held_way));
            chk("bp_rdy_low", 32'(vreq_rdy_o), 32'd0);
        end
        cycle(1'b0, 0, 0, 1'b1, 11, 8'h00, 1'b1, 1'b0);
        chk("bp_b2b_set", 32'(vresp_set_o), 32'd11);
        chk("bp_b2b_vld", 32'(vresp_vld_o), 32'd1);
        idle(1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        idle(1'b1);

        // Flush during a held response: response survives, all trees restart.
        cycle(1'b0, 0, 0, 1'b1, 20, 8'h00, 1'b0, 1'b0);
        held_way = m_way;
        cycle(1'b1, 20, 3, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        chk("flush_keep_set", 32'(vresp_set_o), 32'd20);
        chk("flush_keep_way", 32'(vresp_way_o), 32'(held_way));
        idle(1'b1);
        sets = '{0, 3, 5, 7, 20, 63};
        for (int i = 0; i < 6; i++) begin
            req(sets[i], 8'h00);
            chk("post_flush_way0", 32'(vresp_way_o), 32'd0);
        end
        idle(1'b1);

        // Reset mid-response drops it.
        cycle(1'b0, 0, 0, 1'b1, 1, 8'h00, 1'b0, 1'b0);
        rst         = 1'b1;
        vreq_vld_i  = 1'b0;
        vresp_rdy_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        m_vld = 1'b0;
        chk("rst_resp_drop", 32'(vresp_vld_o), 32'd0);
        chk("rst_resp_rdy", 32'(vreq_rdy_o), 32'd1);
        req(1, 8'h00);
        chk("post_rst_way0", 32'(vresp_way_o), 32'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
